// File: rtl/sender_stream_memory.sv
// Word RAM with a host read/write port and a burst engine that streams Length words from StartAddr.
// Host read data lands one cycle after ReadEnable; the stream issues at most one word per 2 cycles and holds each word until StreamReady.
module sender_stream_memory #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] DataIn,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic                  WriteEnable,
  input  logic                  ReadEnable,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  ReadValid,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] StartAddr,
  input  logic [ADDR_WIDTH:0]   Length,
  input  logic                  Abort,
  output logic                  Busy,
  output logic [DATA_WIDTH-1:0] StreamData,
  output logic                  StreamValid,
  input  logic                  StreamReady,
  output logic                  Done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   REM_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  read_valid_q, read_valid_d;
  logic [DATA_WIDTH-1:0] stream_data_q, stream_data_d;
  logic                  stream_valid_q, stream_valid_d;
  logic                  done_q, done_d;

  // Host writes are accepted in every state; reads of the same edge see the old word.
  always_ff @(posedge clk) begin
    if (WriteEnable) begin
      mem_q[Address] <= DataIn;
    end
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    rem_d          = rem_q;
    data_out_d     = data_out_q;
    read_valid_d   = 1'b0;
    stream_data_d  = stream_data_q;
    stream_valid_d = stream_valid_q;
    done_d         = 1'b0;

    case (state_q)
      IDLE: begin
        if (ReadEnable) begin
          data_out_d   = mem_q[Address];
          read_valid_d = 1'b1;
        end
        if (Start) begin
          if (Length != '0) begin
            ptr_d   = StartAddr;
            rem_d   = Length;
            state_d = FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FETCH: begin
        stream_data_d  = mem_q[ptr_q];
        stream_valid_d = 1'b1;
        state_d        = SEND;
      end
      SEND: begin
        if (StreamReady) begin
          stream_valid_d = 1'b0;
          if (rem_q == REM_ONE) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            rem_d   = rem_q - REM_ONE;
            ptr_d   = ptr_q + PTR_ONE;
            state_d = FETCH;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides a same-cycle handshake and suppresses Done.
    if (Abort && (state_q != IDLE)) begin
      state_d        = IDLE;
      stream_valid_d = 1'b0;
      done_d         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      rem_q          <= '0;
      data_out_q     <= '0;
      read_valid_q   <= 1'b0;
      stream_data_q  <= '0;
      stream_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      rem_q          <= rem_d;
      data_out_q     <= data_out_d;
      read_valid_q   <= read_valid_d;
      stream_data_q  <= stream_data_d;
      stream_valid_q <= stream_valid_d;
      done_q         <= done_d;
    end
  end

  assign DataOut     = data_out_q;
  assign ReadValid   = read_valid_q;
  assign StreamData  = stream_data_q;
  assign StreamValid = stream_valid_q;
  assign Done        = done_q;
  assign Busy        = (state_q != IDLE);

endmodule

// File: tb/tb_sender_stream_memory.sv
// Scoreboard bench: driver pushes expected host reads / stream words / Done pulses,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_sender_stream_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] DataIn;
  logic [3:0]  Address;
  logic        WriteEnable;
  logic        ReadEnable;
  logic [15:0] DataOut;
  logic        ReadValid;
  logic        Start;
  logic [3:0]  StartAddr;
  logic [4:0]  Length;
  logic        Abort;
  logic        Busy;
  logic [15:0] StreamData;
  logic        StreamValid;
  logic        StreamReady;
  logic        Done;

  sender_stream_memory #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .DataIn(DataIn), .Address(Address),
    .WriteEnable(WriteEnable), .ReadEnable(ReadEnable), .DataOut(DataOut),
    .ReadValid(ReadValid), .Start(Start), .StartAddr(StartAddr), .Length(Length),
    .Abort(Abort), .Busy(Busy), .StreamData(StreamData), .StreamValid(StreamValid),
    .StreamReady(StreamReady), .Done(Done)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] model_mem [16];
  logic [15:0] rd_q [$];
  logic [15:0] str_q [$];
  int          done_pending = 0;
  int          acc_cnt = 0;
  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  logic        prev_kill = 1'b1;
  logic [15:0] prev_d = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // Monitor: samples mid-cycle, so inputs seen here are the ones the next edge uses.
  always @(negedge clk) begin
    if (prev_v && !prev_r && !prev_kill) begin
      chk("stream_hold_valid", {31'b0, StreamValid}, 32'd1);
      chk("stream_hold_data", {16'b0, StreamData}, {16'b0, prev_d});
    end
    if (ReadValid === 1'b1) begin
      if (rd_q.size() == 0) fail("read_unexpected");
      else chk("read_data", {16'b0, DataOut}, {16'b0, rd_q.pop_front()});
    end
    if (StreamValid === 1'b1 && StreamReady && !rst && !Abort) begin
      if (str_q.size() == 0) fail("stream_unexpected");
      else chk("stream_word", {16'b0, StreamData}, {16'b0, str_q.pop_front()});
      acc_cnt++;
    end
    if (Done === 1'b1) begin
      chk("done_valid_low", {31'b0, StreamValid}, 32'd0);
      if (done_pending == 0) fail("done_unexpected");
      else done_pending--;
    end
    prev_v    = (StreamValid === 1'b1);
    prev_r    = StreamReady;
    prev_d    = StreamData;
    prev_kill = rst || Abort;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dataout"}, {16'b0, DataOut}, 32'd0);
    chk({tag, "_readvalid"}, {31'b0, ReadValid}, 32'd0);
    chk({tag, "_streamdata"}, {16'b0, StreamData}, 32'd0);
    chk({tag, "_streamvalid"}, {31'b0, StreamValid}, 32'd0);
    chk({tag, "_busy"}, {31'b0, Busy}, 32'd0);
    chk({tag, "_done"}, {31'b0, Done}, 32'd0);
  endtask

  task automatic host_write(input int a, input logic [15:0] d);
    Address = 4'(a);
    DataIn = d;
    WriteEnable = 1'b1;
    tick();
    WriteEnable = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic host_read(input int a);
    Address = 4'(a);
    ReadEnable = 1'b1;
    rd_q.push_back(model_mem[a]);
    tick();
    ReadEnable = 1'b0;
    chk("read_valid_1cyc", {31'b0, ReadValid}, 32'd1);
  endtask

  task automatic recover();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    str_q.delete();
    rd_q.delete();
    done_pending = 0;
  endtask

  // abort_at / stall_at are 0-based word indices, -1 disables.
  task automatic burst(input int sa, input int len, input int rdy_pct, input int abort_at,
                       input int stall_at, input int stall_n, input bit rd_during);
    int cyc;
    int base;
    int stall_left;
    StartAddr = 4'(sa);
    Length = 5'(len);
    Start = 1'b1;
    for (int i = 0; i < len; i++) str_q.push_back(model_mem[(sa + i) % 16]);
    done_pending++;
    base = acc_cnt;
    tick();
    Start = 1'b0;
    if (len == 0) begin
      chk("len0_done", {31'b0, Done}, 32'd1);
      chk("len0_busy", {31'b0, Busy}, 32'd0);
      chk("len0_valid", {31'b0, StreamValid}, 32'd0);
      tick();
      chk("len0_done_once", {31'b0, Done}, 32'd0);
      chk("len0_busy2", {31'b0, Busy}, 32'd0);
      chk("len0_valid2", {31'b0, StreamValid}, 32'd0);
      return;
    end
    chk("start_busy", {31'b0, Busy}, 32'd1);
    chk("start_valid_not_yet", {31'b0, StreamValid}, 32'd0);
    stall_left = stall_n;
    cyc = 0;
    while (Busy && cyc < 400) begin
      cyc++;
      ReadEnable = rd_during ? 1'($urandom_range(0, 1)) : 1'b0;
      Address = 4'($urandom_range(0, 15));
      if (abort_at >= 0 && (acc_cnt - base) == abort_at && StreamValid) begin
        Abort = 1'b1;
        StreamReady = 1'b0;
        tick();
        Abort = 1'b0;
        ReadEnable = 1'b0;
        str_q.delete();
        done_pending = 0;
        chk("abort_busy", {31'b0, Busy}, 32'd0);
        chk("abort_valid", {31'b0, StreamValid}, 32'd0);
        chk("abort_no_done", {31'b0, Done}, 32'd0);
        return;
      end
      if (stall_at >= 0 && (acc_cnt - base) == stall_at && StreamValid && stall_left > 0) begin
        StreamReady = 1'b0;
        stall_left--;
      end else begin
        StreamReady = ($urandom_range(1, 100) <= rdy_pct);
      end
      tick();
    end
    ReadEnable = 1'b0;
    StreamReady = 1'b0;
    if (cyc >= 400) begin
      fail("burst_timeout");
      recover();
      return;
    end
    chk("end_done_pulse", {31'b0, Done}, 32'd1);
    if (rdy_pct == 100 && stall_n == 0) chk("burst_cycles", 32'(cyc), 32'(2 * len));
    @(negedge clk);
    #1;
    chk("burst_word_count", 32'(acc_cnt - base), 32'(len));
    chk("burst_queue_empty", 32'(str_q.size()), 32'd0);
    chk("burst_done_seen", 32'(done_pending), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    rst = 1'b1; DataIn = '0; Address = '0; WriteEnable = 1'b0; ReadEnable = 1'b0;
    Start = 1'b0; StartAddr = '0; Length = '0; Abort = 1'b0; StreamReady = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    host_write(15, 16'hABCD);
    host_read(15);
    tick();
    chk("read_valid_single", {31'b0, ReadValid}, 32'd0);

    for (int i = 0; i < 16; i++) host_write(i, 16'(i + 1));
    burst(14, 4, 100, -1, -1, 0, 1'b0);
    burst(14, 4, 100, -1, 1, 5, 1'b0);
    burst(0, 0, 100, -1, -1, 0, 1'b0);
    burst(0, 4, 100, 1, -1, 0, 1'b0);
    host_read(5);
    burst(3, 20, 100, -1, -1, 0, 1'b1);

    StartAddr = 4'd3; Length = 5'd6; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("midburst_rst");
    rst = 1'b0;
    tick();
    Address = 4'd3; DataIn = 16'h5A5A; WriteEnable = 1'b1; ReadEnable = 1'b1;
    rd_q.push_back(model_mem[3]);
    tick();
    model_mem[3] = 16'h5A5A;
    WriteEnable = 1'b0; ReadEnable = 1'b0;
    chk("rbw_read_valid", {31'b0, ReadValid}, 32'd1);
    host_read(3);

    for (int it = 0; it < 40; it++) begin
      int op;
      int len;
      op = $urandom_range(0, 5);
      if (op == 0) host_write($urandom_range(0, 15), 16'($urandom));
      else if (op == 1) host_read($urandom_range(0, 15));
      else begin
        len = $urandom_range(0, 31);
        burst($urandom_range(0, 15), len, $urandom_range(30, 100),
              ($urandom_range(0, 3) == 0 && len > 0) ? $urandom_range(0, len - 1) : -1,
              -1, 0, 1'($urandom_range(0, 1)));
      end
      tick();
    end

    repeat (2) tick();
    chk("final_read_queue_empty", 32'(rd_q.size()), 32'd0);
    chk("final_done_pending", 32'(done_pending), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
